// File: rtl/des_host_seq.sv
// Host command sequencer feeding the 3DES control unit: turns host commands and byte streams into per-cycle mode codes.
// Optional RUN watchdog enabled by defining DES_HOST_SEQ_TIMEOUT_EN.
module des_host_seq #(
    parameter int KEY_BYTES      = 8,
    parameter int DATA_BYTES     = 8,
    parameter int OUT_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd,
    output logic       cmd_ready,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       core_done,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [2:0] mode,
    output logic       busy,
    output logic       err
);

    localparam int MAX_KD = (KEY_BYTES > DATA_BYTES) ? KEY_BYTES : DATA_BYTES;
    localparam int MAX_B  = (MAX_KD > OUT_BYTES) ? MAX_KD : OUT_BYTES;
    localparam int CW     = $clog2(MAX_B) + 1;

    localparam logic [CW-1:0] KEY_LAST  = CW'(KEY_BYTES - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);
    localparam logic [CW-1:0] OUT_LAST  = CW'(OUT_BYTES - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD_KEY  = 3'd1;
    localparam logic [2:0] S_LOAD_DATA = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_CLEAR     = 3'd4;
    localparam logic [2:0] S_READ      = 3'd5;

    localparam logic [2:0] MODE_IDLE  = 3'd0;
    localparam logic [2:0] MODE_KEY   = 3'd1;
    localparam logic [2:0] MODE_DATA  = 3'd2;
    localparam logic [2:0] MODE_ENC   = 3'd3;
    localparam logic [2:0] MODE_DEC   = 3'd4;
    localparam logic [2:0] MODE_CLEAR = 3'd5;
    localparam logic [2:0] MODE_SHOUT = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          dec_q, dec_d;

`ifdef DES_HOST_SEQ_TIMEOUT_EN
    localparam int              WDW     = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic [WDW-1:0] wd_q, wd_d;
    // Set when CLEAR was entered by the watchdog, so that CLEAR keeps err raised.
    logic           keep_q, keep_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        dec_d     = dec_q;
        mode      = MODE_IDLE;
        cmd_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef DES_HOST_SEQ_TIMEOUT_EN
        wd_d      = wd_q;
        keep_d    = keep_q;
`endif
        case (state_q)
            S_IDLE: begin
                cmd_ready = ~rst;
                if (cmd_valid && !rst) begin
                    case (cmd)
                        3'd1: state_d = S_LOAD_KEY;
                        3'd2: state_d = S_LOAD_DATA;
                        3'd3, 3'd4: begin
                            state_d = S_RUN;
                            dec_d   = (cmd == 3'd4);
`ifdef DES_HOST_SEQ_TIMEOUT_EN
                            wd_d    = '0;
`endif
                        end
                        3'd5: state_d = S_CLEAR;
                        3'd6: state_d = S_READ;
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD_KEY: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mode = MODE_KEY;
                    if (cnt_q == KEY_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_LOAD_DATA: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mode = MODE_DATA;
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_RUN: begin
                mode = dec_q ? MODE_DEC : MODE_ENC;
                if (core_done) begin
                    state_d = S_IDLE;
                end
`ifdef DES_HOST_SEQ_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d = S_CLEAR;
                    err_d   = 1'b1;
                    keep_d  = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_CLEAR: begin
                mode    = MODE_CLEAR;
                state_d = S_IDLE;
                cnt_d   = '0;
`ifdef DES_HOST_SEQ_TIMEOUT_EN
                err_d   = keep_q;
                keep_d  = 1'b0;
`else
                err_d   = 1'b0;
`endif
            end
            S_READ: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    mode = MODE_SHOUT;
                    if (cnt_q == OUT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            dec_q   <= dec_d;
        end
    end

`ifdef DES_HOST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q   <= '0;
            keep_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            keep_q <= keep_d;
        end
    end
`endif

    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule
